// File: rtl/bsg_pipeline_stall_collapse_kill.sv
// bsg_pipeline_stall_collapse_kill
// Valid-bit tracker and data-enable generator for a stages_p-deep pipeline.
// Stage stages_p-1 is the input end, stage 0 the output end. Supports
// bubble-collapse or lockstep stalling, per-stage kill, whole-pipe flush and
// an occupancy count.
// Optional feature: define BSG_PIPELINE_COLLAPSE_PERF_EN to build a
// saturating stall-cycle counter on stall_cnt_o; otherwise it reads '0.
module bsg_pipeline_stall_collapse_kill #(
  parameter int unsigned            stages_p    = 4,
  parameter logic [stages_p-1:0]    skip_p      = '0,
  parameter bit                     collapse_p  = 1'b1,
  parameter int unsigned            cnt_width_p = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          valid_i,
  output logic                          ready_and_o,
  output logic                          valid_o,
  input  logic                          ready_and_i,
  input  logic [stages_p-1:0]           kill_i,
  input  logic                          flush_i,
  output logic [stages_p-1:0]           en_o,
  output logic [$clog2(stages_p+1)-1:0] count_o,
  output logic [cnt_width_p-1:0]        stall_cnt_o
);

  logic [stages_p-1:0] v_q;
  logic [stages_p-1:0] v_d;
  logic [stages_p-1:0] v_li;
  logic [stages_p-1:0] v_eff;
  logic [stages_p-1:0] full;
  logic [stages_p-1:0] adv;

  // Valid propagation, advance conditions, enables and next valid state.
  // v_li/v_eff are built with a running carry from the input end downward
  // so no vector bit is computed from another bit of the same vector.
  always_comb begin
    logic carry;
    logic acc;
    v_li  = '0;
    v_eff = '0;
    full  = '0;
    adv   = '0;
    en_o  = '0;
    v_d   = '0;
    carry = valid_i;
    for (int i = int'(stages_p) - 1; i >= 0; i--) begin
      v_li[i] = carry;
      if (skip_p[i]) v_eff[i] = carry;
      else           v_eff[i] = v_q[i] & ~kill_i[i];
      carry = v_eff[i];
    end
    acc = 1'b1;
    for (int unsigned i = 0; i < stages_p; i++) begin
      acc     = acc & v_eff[i];
      full[i] = acc;
    end
    for (int unsigned i = 0; i < stages_p; i++) begin
      if (collapse_p) adv[i] = ready_and_i | ~full[i];
      else            adv[i] = ready_and_i | ~v_eff[0];
      if (!skip_p[i]) begin
        en_o[i] = v_li[i] & adv[i] & ~flush_i;
        if (flush_i)     v_d[i] = 1'b0;
        else if (adv[i]) v_d[i] = v_li[i];
        else             v_d[i] = v_eff[i];
      end
    end
  end

  // Per-stage valid register; skip stages stay constant zero.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) v_q <= '0;
    else            v_q <= v_d;
  end

  // Occupancy from registered valids only (not reduced by this cycle's kill).
  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < stages_p; i++) begin
      count_o = count_o + {{($clog2(stages_p+1)-1){1'b0}}, v_q[i]};
    end
  end

  assign valid_o     = v_eff[0];
  assign ready_and_o = adv[stages_p-1] & ~flush_i;

`ifdef BSG_PIPELINE_COLLAPSE_PERF_EN
  logic [cnt_width_p-1:0] stall_cnt_q;
  logic [cnt_width_p-1:0] stall_cnt_d;

  // Saturating count of cycles where the consumer holds off valid output.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush_i)
      stall_cnt_d = '0;
    else if (valid_o && !ready_and_i && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) stall_cnt_q <= '0;
    else            stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
